// File: rtl/down_counter_if.sv
// ============================================================================
//  Module      : down_counter_if
//  Description : Control/status bundle for down_counter. The master side
//                issues load/enable/start; the slave side (the counter)
//                returns the count and its status flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface down_counter_if #(
  parameter int WIDTH = 8
);

  logic             enable;  // count-down enable
  logic             load;    // one-cycle load request
  logic [WIDTH-1:0] start;   // reload value
  logic [WIDTH-1:0] out;     // current count (registered)
  logic             busy;    // counting in progress
  logic             done;    // terminal-count pulse
  logic             zero;    // out == 0 (combinational)

  // Controller side: drives requests, observes the counter.
  modport master (
    output enable,
    output load,
    output start,
    input  out,
    input  busy,
    input  done,
    input  zero
  );

  // Counter side: consumes requests, reports count and status.
  modport slave (
    input  enable,
    input  load,
    input  start,
    output out,
    output busy,
    output done,
    output zero
  );

endinterface

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
//  Module      : down_counter
//  Description : Loadable down counter with terminal-count detection. Used as
//                a measurement-window timer: load a cycle count, decrement on
//                enable, stop at zero and pulse done for one cycle.
//                Optional macro DOWN_COUNTER_AUTO_RELOAD_EN turns the DONE
//                cycle into an automatic reload, giving a periodic timer with
//                period start + 1 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module down_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;

  // Next-count candidates used by the state machine.
  logic [WIDTH-1:0] out_dec_d;
  logic             start_nz_d;
  logic             last_step_d;

  // Decrement path; only taken when out_q > 1, so it never wraps.
  always_comb begin
    out_dec_d   = out_q - C_ONE;
    start_nz_d  = (bus.start != C_ZERO);
    // out_q == 0 cannot occur in COUNT; treating it as the last step anyway
    // keeps the counter from ever wrapping if the register were disturbed.
    last_step_d = (out_q <= C_ONE);
  end

  // Counter state machine with registered count and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= bus.start;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.load) begin
      // Load wins from every state; a zero load goes straight to DONE.
      out_q   <= bus.start;
      state_q <= start_nz_d ? COUNT : DONE;
      busy_q  <= start_nz_d;
      done_q  <= ~start_nz_d;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        COUNT: begin
          if (bus.enable && last_step_d) begin
            out_q   <= C_ZERO;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            if (bus.enable) begin
              out_q <= out_dec_d;
            end
            state_q <= COUNT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          // Periodic mode: restart the window from the current start value.
          out_q   <= bus.start;
          state_q <= start_nz_d ? COUNT : DONE;
          busy_q  <= start_nz_d;
          done_q  <= ~start_nz_d;
`else
          // One-shot mode: park at zero until the next load or reset.
          out_q   <= C_ZERO;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
`endif
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs; zero is decoded straight from the count register.
  always_comb begin
    bus.out  = out_q;
    bus.busy = busy_q;
    bus.done = done_q;
    bus.zero = (out_q == C_ZERO);
  end

endmodule

`default_nettype wire

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down counter with terminal-count detection; it is the count-down counterpart to the existing up_counter.
- Loads `start`, decrements on `enable`, stops at zero and issues a one-cycle `done` pulse.
- Used as a measurement-window timer in the PUF datapath: it gates the ring-oscillator edge counters for a programmable number of clock cycles.
- Single clock domain.

Parameters:
- WIDTH, 8, width of `start` and `out`.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  count-down enable; when low, `out` holds.
- load  input  1  one-cycle request to load `start` and begin counting.
- start  input  WIDTH  reload value, sampled on `reset` or `load`.
- out  output  WIDTH  current count, registered.
- busy  output  1  high while in state COUNT.
- done  output  1  terminal-count pulse, registered, high only while in state DONE.
- zero  output  1  combinational, equals (out == 0).

Behaviour:
- States: IDLE, COUNT, DONE. State and `out` are registered. `busy` and `done` are decoded from state.
- Reset (synchronous, highest priority):
  - state <= IDLE; out <= start; busy = 0; done = 0.
  - Applies mid-count too; any count in progress is abandoned.
- IDLE:
  - `out` holds; `enable` is ignored.
  - load=1: out <= start. Next state is COUNT if start != 0, otherwise DONE.
- COUNT:
  - load=1 has priority over decrement: out <= start, and the next state follows the same rule as from IDLE.
  - enable=1, out > 1: out <= out - 1; stay in COUNT.
  - enable=1, out == 1: out <= 0; next state DONE.
  - enable=0: `out` holds; stay in COUNT.
  - out == 0 is never present in COUNT, so no underflow or wrap path exists.
- DONE:
  - Lasts exactly one cycle; `done` = 1 for that cycle; out = 0.
  - load=1: out <= start; next state per the IDLE rule (back-to-back runs allowed).
  - Otherwise the next state depends on AUTO_RELOAD_EN (see Optional Feature).
- Latency:
  - Load at edge k gives out = start after edge k.
  - With `enable` held high, `done` is asserted in the cycle after edge k + start.
  - Loading start=0 gives DONE immediately after the loading edge.
- `start` changes: ignored except at reset or load.
- Widths: decrement is modulo-free WIDTH-bit arithmetic, guarded so it never wraps. Max start = 2^WIDTH - 1.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined, DONE with load=0:
  - out <= start; next state COUNT if start != 0, otherwise DONE again.
  - This gives a periodic timer with period start + 1 cycles while `enable` is held high.
  - `busy` deasserts only during DONE cycles.
- Undefined, DONE with load=0:
  - Next state IDLE; out holds 0; zero = 1 until the next load or reset.

Test Plan:
1. Reset with start=8'hFA held for 2 cycles.
   - Required: out=8'hFA, busy=0, done=0, zero=0.
   - Then with load=0 and enable=1 for 5 cycles: out stays 8'hFA (IDLE ignores enable).
2. start=8'h05, load pulse, enable=1.
   - Required: out sequence 5,4,3,2,1,0.
   - done high for exactly one cycle, coincident with the first out=0 cycle.
   - busy falls the same cycle.
   - Without the macro: state IDLE afterwards, out stays 0.
3. start=8'h0A, load pulse, enable=1 for 3 cycles (out=7), then enable=0 for 4 cycles, then enable=1.
   - Required: out holds 7 while enable is low, then resumes 6,5,...
   - done asserted 7 cycles after enable returns.
4. Counting at out=3, assert reset for 1 cycle with start=8'h20.
   - Required: out=8'h20, state IDLE, busy=0, no done pulse.
   - In a separate run, load with start=8'h09 at out=4: out=9, busy stays 1.
5. Boundary cases:
   - load with start=8'h00: done pulses the next cycle, busy never asserts.
   - start=8'hFF, enable=1: done after 255 decrements; no wrap to 8'hFF after 0.
6. Compile with DOWN_COUNTER_AUTO_RELOAD_EN, start=8'h03, load once, enable=1 for 12 cycles.
   - Required: out 3,2,1,0,3,2,1,0,...
   - done pulses every 4 cycles.
